// File: rtl/bus_arbiter_nm.sv
// N-master to one-slave bus arbiter with fixed-priority or round-robin grant
// and an in-order queue that routes read responses back to the issuing master.
module bus_arbiter_nm #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RESP_DEPTH  = 4,
  parameter int ARB_MODE    = 0
)(
  input  logic                              clk_i,
  input  logic                              arst_n_i,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr_bi,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_be_bi,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata_bi,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_resp_o,
  output logic [NUM_MASTERS*DATA_W-1:0]     m_rdata_bo,
  output logic                              s_req_o,
  output logic                              s_we_o,
  output logic [ADDR_W-1:0]                 s_addr_bo,
  output logic [DATA_W/8-1:0]               s_be_bo,
  output logic [DATA_W-1:0]                 s_wdata_bo,
  input  logic                              s_ack_i,
  input  logic                              s_resp_i,
  input  logic [DATA_W-1:0]                 s_rdata_bi,
  output logic                              busy_o,
  output logic                              err_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic [NUM_MASTERS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_MASTERS-1:0][BE_W-1:0]   be_a;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_MASTERS-1:0][DATA_W-1:0] rdata_a;

  assign addr_a     = m_addr_bi;
  assign be_a       = m_be_bi;
  assign wdata_a    = m_wdata_bi;
  assign m_rdata_bo = rdata_a;

  logic [IDX_W-1:0]       q_mem [RESP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [IDX_W-1:0]       rr_ptr, gnt_idx, head;
  logic                   gnt_vld, full, empty, accept, push, pop;
  logic [NUM_MASTERS-1:0] elig;

  assign full  = (count == CNT_W'(RESP_DEPTH));
  assign empty = (count == '0);
  // Writes bypass the queue, so only reads are held off when it is full.
  assign elig  = m_req_i & (m_we_i | {NUM_MASTERS{!full}});

  always_comb begin
    int k;
    k       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (ARB_MODE == 0) begin
      for (int j = NUM_MASTERS - 1; j >= 0; j--)
        if (elig[j]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(j);
        end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        k = (int'(rr_ptr) + i) % NUM_MASTERS;
        if (!gnt_vld && elig[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(k);
        end
      end
    end
  end

  assign s_req_o    = gnt_vld & arst_n_i;
  assign s_we_o     = s_req_o & m_we_i[gnt_idx];
  assign s_addr_bo  = s_req_o ? addr_a[gnt_idx]  : '0;
  assign s_be_bo    = s_req_o ? be_a[gnt_idx]    : '0;
  assign s_wdata_bo = s_req_o ? wdata_a[gnt_idx] : '0;

  assign accept = s_req_o & s_ack_i;
  assign push   = accept & ~s_we_o;
  assign head   = q_mem[rd_ptr];
  assign pop    = arst_n_i & s_resp_i & ~empty;
  assign busy_o = ~empty;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    assign m_ack_o[g]  = accept & (gnt_idx == IDX_W'(g));
    assign m_resp_o[g] = pop & (head == IDX_W'(g));
    assign rdata_a[g]  = m_resp_o[g] ? s_rdata_bi : '0;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (s_resp_i && empty) err_o <= 1'b1;
      if (ARB_MODE != 0 && accept)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i)
    if (push) q_mem[wr_ptr] <= gnt_idx;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Directed bench: a 2-master fixed-priority instance and a 4-master
// round-robin instance with a 2-deep response queue, sharing one clock.
module tb_bus_arbiter_nm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NUM_MASTERS=2, ARB_MODE=0, RESP_DEPTH=4, 16-bit addr/data
  logic        a_rst_n;
  logic [1:0]  a_m_req, a_m_we, a_m_ack, a_m_resp;
  logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;
  logic [3:0]  a_m_be;
  logic        a_s_req, a_s_we, a_s_ack, a_s_resp, a_busy, a_err;
  logic [15:0] a_s_addr, a_s_wdata, a_s_rdata;
  logic [1:0]  a_s_be;

  // Instance B: NUM_MASTERS=4, ARB_MODE=1, RESP_DEPTH=2, 16-bit addr/data
  logic        b_rst_n;
  logic [3:0]  b_m_req, b_m_we, b_m_ack, b_m_resp;
  logic [63:0] b_m_addr, b_m_wdata, b_m_rdata;
  logic [7:0]  b_m_be;
  logic        b_s_req, b_s_we, b_s_ack, b_s_resp, b_busy, b_err;
  logic [15:0] b_s_addr, b_s_wdata, b_s_rdata;
  logic [1:0]  b_s_be;

  bus_arbiter_nm #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(16), .RESP_DEPTH(4), .ARB_MODE(0)) u_a (
    .clk_i(clk), .arst_n_i(a_rst_n),
    .m_req_i(a_m_req), .m_we_i(a_m_we), .m_addr_bi(a_m_addr), .m_be_bi(a_m_be),
    .m_wdata_bi(a_m_wdata), .m_ack_o(a_m_ack), .m_resp_o(a_m_resp), .m_rdata_bo(a_m_rdata),
    .s_req_o(a_s_req), .s_we_o(a_s_we), .s_addr_bo(a_s_addr), .s_be_bo(a_s_be),
    .s_wdata_bo(a_s_wdata), .s_ack_i(a_s_ack), .s_resp_i(a_s_resp), .s_rdata_bi(a_s_rdata),
    .busy_o(a_busy), .err_o(a_err)
  );

  bus_arbiter_nm #(.NUM_MASTERS(4), .ADDR_W(16), .DATA_W(16), .RESP_DEPTH(2), .ARB_MODE(1)) u_b (
    .clk_i(clk), .arst_n_i(b_rst_n),
    .m_req_i(b_m_req), .m_we_i(b_m_we), .m_addr_bi(b_m_addr), .m_be_bi(b_m_be),
    .m_wdata_bi(b_m_wdata), .m_ack_o(b_m_ack), .m_resp_o(b_m_resp), .m_rdata_bo(b_m_rdata),
    .s_req_o(b_s_req), .s_we_o(b_s_we), .s_addr_bo(b_s_addr), .s_be_bo(b_s_be),
    .s_wdata_bo(b_s_wdata), .s_ack_i(b_s_ack), .s_resp_i(b_s_resp), .s_rdata_bi(b_s_rdata),
    .busy_o(b_busy), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Return 1 time unit after the next rising edge; inputs change here.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_idx [4];
    rr_idx[0] = 2'd0; rr_idx[1] = 2'd1; rr_idx[2] = 2'd3; rr_idx[3] = 2'd0;

    a_rst_n = 1'b0; a_m_req = '0; a_m_we = '0; a_m_addr = '0; a_m_be = '0; a_m_wdata = '0;
    a_s_ack = 1'b0; a_s_resp = 1'b0; a_s_rdata = '0;
    b_rst_n = 1'b0; b_m_req = '0; b_m_we = '0; b_m_addr = '0; b_m_be = '0; b_m_wdata = '0;
    b_s_ack = 1'b0; b_s_resp = 1'b0; b_s_rdata = '0;

    // Outputs forced low while reset is held, even with active inputs
    #2;
    a_m_req = 2'b11; a_s_ack = 1'b1; a_s_resp = 1'b1;
    b_m_req = 4'hF;  b_s_ack = 1'b1; b_s_resp = 1'b1;
    #1;
    chk("rst_a_s_req",  a_s_req,  0);
    chk("rst_a_m_ack",  a_m_ack,  0);
    chk("rst_a_m_resp", a_m_resp, 0);
    chk("rst_a_busy",   a_busy,   0);
    chk("rst_a_err",    a_err,    0);
    chk("rst_b_s_req",  b_s_req,  0);
    chk("rst_b_m_ack",  b_m_ack,  0);
    chk("rst_b_m_resp", b_m_resp, 0);
    a_m_req = '0; a_s_ack = 1'b0; a_s_resp = 1'b0;
    b_m_req = '0; b_s_ack = 1'b0; b_s_resp = 1'b0;
    #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    next();

    // A: both masters read, fixed priority, response one cycle after ack
    a_m_addr = {16'h0200, 16'h0100}; a_m_we = 2'b00; a_m_req = 2'b11; a_s_ack = 1'b1;
    #1;
    chk("fp_c1_s_req",  a_s_req,  1);
    chk("fp_c1_s_we",   a_s_we,   0);
    chk("fp_c1_s_addr", a_s_addr, 16'h0100);
    chk("fp_c1_m_ack",  a_m_ack,  2'b01);
    next();
    a_m_req = 2'b10; a_s_resp = 1'b1; a_s_rdata = 16'h0100;
    #1;
    chk("fp_c2_s_addr",  a_s_addr,  16'h0200);
    chk("fp_c2_m_ack",   a_m_ack,   2'b10);
    chk("fp_c2_m_resp",  a_m_resp,  2'b01);
    chk("fp_c2_m_rdata", a_m_rdata, 32'h0000_0100);
    chk("fp_c2_busy",    a_busy,    1);
    next();
    a_m_req = 2'b00; a_s_ack = 1'b0; a_s_rdata = 16'h0200;
    #1;
    chk("fp_c3_s_req",   a_s_req,   0);
    chk("fp_c3_s_addr",  a_s_addr,  0);
    chk("fp_c3_m_resp",  a_m_resp,  2'b10);
    chk("fp_c3_m_rdata", a_m_rdata, 32'h0200_0000);
    next();
    a_s_resp = 1'b0;
    #1;
    chk("fp_c4_busy", a_busy, 0);
    chk("fp_c4_err",  a_err,  0);

    // A: write from m0 beats a read from m1; fields muxed, nothing queued
    a_m_req = 2'b11; a_m_we = 2'b01; a_m_be = {2'b11, 2'b01};
    a_m_wdata = {16'hBEEF, 16'h1234}; a_s_ack = 1'b1;
    #1;
    chk("wr_s_we",    a_s_we,    1);
    chk("wr_s_be",    a_s_be,    2'b01);
    chk("wr_s_wdata", a_s_wdata, 16'h1234);
    chk("wr_m_ack",   a_m_ack,   2'b01);
    next();
    a_m_req = 2'b00; a_m_we = 2'b00; a_s_ack = 1'b0;
    #1;
    chk("wr_busy", a_busy, 0);

    // A: pipelined reads m1, m0, m1 with responses three cycles later
    a_m_addr = {16'h0030, 16'h0020}; a_s_ack = 1'b1;
    a_m_req = 2'b10;
    #1;
    chk("pl_c1_m_ack", a_m_ack, 2'b10);
    chk("pl_c1_resp",  a_m_resp, 0);
    next();
    a_m_req = 2'b01;
    #1;
    chk("pl_c2_m_ack", a_m_ack, 2'b01);
    chk("pl_c2_resp",  a_m_resp, 0);
    next();
    a_m_req = 2'b10;
    #1;
    chk("pl_c3_m_ack", a_m_ack, 2'b10);
    chk("pl_c3_resp",  a_m_resp, 0);
    next();
    a_m_req = 2'b00; a_s_ack = 1'b0; a_s_resp = 1'b1; a_s_rdata = 16'h000A;
    #1;
    chk("pl_c4_resp",  a_m_resp,  2'b10);
    chk("pl_c4_rdata", a_m_rdata, 32'h000A_0000);
    next();
    a_s_rdata = 16'h000B;
    #1;
    chk("pl_c5_resp",  a_m_resp,  2'b01);
    chk("pl_c5_rdata", a_m_rdata, 32'h0000_000B);
    next();
    a_s_rdata = 16'h000C;
    #1;
    chk("pl_c6_resp",  a_m_resp,  2'b10);
    chk("pl_c6_rdata", a_m_rdata, 32'h000C_0000);
    next();
    a_s_resp = 1'b0;
    #1;
    chk("pl_c7_resp", a_m_resp, 0);
    chk("pl_c7_busy", a_busy,   0);
    chk("pl_c7_err",  a_err,    0);

    // A: spurious response with an empty queue sets sticky error
    a_s_resp = 1'b1; a_s_rdata = 16'h00FF;
    #1;
    chk("sp_resp",  a_m_resp,  0);
    chk("sp_rdata", a_m_rdata, 0);
    next();
    a_s_resp = 1'b0;
    #1;
    chk("sp_err_set", a_err, 1);
    next();
    chk("sp_err_hold", a_err, 1);
    a_rst_n = 1'b0;
    #1;
    chk("sp_err_clr", a_err, 0);
    a_rst_n = 1'b1;
    next();

    // B: round-robin over four writers, then with m2 idle
    b_m_addr = {16'h3000, 16'h2000, 16'h1000, 16'h0000};
    b_m_we = 4'hF; b_m_req = 4'hF; b_s_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_all_%0d", i), b_m_ack, 4'b0001 << (i % 4));
      next();
    end
    b_m_req = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_drop_ack_%0d", i),  b_m_ack,  4'b0001 << rr_idx[i]);
      chk($sformatf("rr_drop_addr_%0d", i), b_s_addr, {2'b00, rr_idx[i], 12'h000});
      next();
    end
    b_m_req = '0; b_s_ack = 1'b0;
    b_rst_n = 1'b0;
    #1;
    b_rst_n = 1'b1;
    next();

    // B: queue depth 2 blocks a third read but not a write
    b_m_we = 4'b0000; b_s_ack = 1'b1; b_m_req = 4'b0001;
    #1;
    chk("dp_c1_ack", b_m_ack, 4'b0001);
    next();
    b_m_req = 4'b0010;
    #1;
    chk("dp_c2_ack", b_m_ack, 4'b0010);
    next();
    b_m_req = 4'b1100; b_m_we = 4'b1000;
    b_m_be = 8'b10_00_00_00; b_m_wdata = {16'hCAFE, 48'h0};
    #1;
    chk("dp_c3_s_req", b_s_req,   1);
    chk("dp_c3_s_we",  b_s_we,    1);
    chk("dp_c3_be",    b_s_be,    2'b10);
    chk("dp_c3_wdata", b_s_wdata, 16'hCAFE);
    chk("dp_c3_ack",   b_m_ack,   4'b1000);
    chk("dp_c3_busy",  b_busy,    1);
    next();
    b_m_req = 4'b0100; b_m_we = 4'b0000;
    #1;
    chk("dp_c4_s_req", b_s_req, 0);
    chk("dp_c4_ack",   b_m_ack, 0);
    chk("dp_c4_busy",  b_busy,  1);
    next();
    b_s_resp = 1'b1; b_s_rdata = 16'h0055;
    #1;
    chk("dp_c5_s_req", b_s_req,   0);
    chk("dp_c5_resp",  b_m_resp,  4'b0001);
    chk("dp_c5_rdata", b_m_rdata, 64'h0055);
    next();
    b_s_resp = 1'b0;
    #1;
    chk("dp_c6_s_req", b_s_req,  1);
    chk("dp_c6_addr",  b_s_addr, 16'h2000);
    chk("dp_c6_ack",   b_m_ack,  4'b0100);
    next();
    b_m_req = '0; b_s_ack = 1'b0;
    #1;
    chk("dp_c7_busy", b_busy, 1);

    // B: reset with two reads outstanding, then a stale response
    b_m_req = 4'hF; b_m_we = 4'hF;
    b_rst_n = 1'b0;
    #1;
    chk("mr_busy_low", b_busy,  0);
    chk("mr_s_req",    b_s_req, 0);
    b_rst_n = 1'b1; b_s_ack = 1'b1;
    #1;
    chk("mr_busy_after", b_busy,  0);
    chk("mr_err_after",  b_err,   0);
    chk("mr_rr_m0",      b_m_ack, 4'b0001);
    next();
    b_m_req = '0; b_s_ack = 1'b0; b_s_resp = 1'b1; b_s_rdata = 16'h0077;
    #1;
    chk("mr_stale_resp", b_m_resp, 0);
    next();
    b_s_resp = 1'b0;
    #1;
    chk("mr_stale_err", b_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
